ras_ctrl: RTL

- Upstream control stage for the return address stack.
- Consumes the decoded instruction stream (call/return/conditional-branch flags plus PC) and the branch-resolution stream.
- Drives the stack's push, pop, branch, close_valid, close_invalid and din strobes, and tracks outstanding speculative branches against stack capacity.
- Registers the stack's read data into a return-target prediction with a valid/hit flag.

---
 rtl/ras_ctrl_if.sv | 39 +++
 rtl/ras_ctrl.sv | 118 +++++++++++
 2 files changed

// File: rtl/ras_ctrl_if.sv
// rtl/ras_ctrl_if.sv - instruction, resolve, stack and prediction bus for ras_ctrl
interface ras_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_pc;
    logic             in_is_call;
    logic             in_is_ret;
    logic             in_is_branch;
    logic             in_is_compressed;
    logic             resolve_valid;
    logic             resolve_mispredict;
    logic             ras_push;
    logic             ras_pop;
    logic             ras_branch;
    logic             ras_close_valid;
    logic             ras_close_invalid;
    logic [WIDTH-1:0] ras_din;
    logic [WIDTH-1:0] ras_dout;
    logic             ras_pop_valid;
    logic             pred_valid;
    logic [WIDTH-1:0] pred_target;
    logic             pred_hit;

    modport master (
        output in_valid, in_pc, in_is_call, in_is_ret, in_is_branch, in_is_compressed,
        output resolve_valid, resolve_mispredict, ras_dout, ras_pop_valid,
        input  in_ready, ras_push, ras_pop, ras_branch, ras_close_valid, ras_close_invalid,
        input  ras_din, pred_valid, pred_target, pred_hit
    );

    modport slave (
        input  in_valid, in_pc, in_is_call, in_is_ret, in_is_branch, in_is_compressed,
        input  resolve_valid, resolve_mispredict, ras_dout, ras_pop_valid,
        output in_ready, ras_push, ras_pop, ras_branch, ras_close_valid, ras_close_invalid,
        output ras_din, pred_valid, pred_target, pred_hit
    );
endinterface

// File: rtl/ras_ctrl.sv
// rtl/ras_ctrl.sv - return address stack control: strobes, branch tracking, prediction
module ras_ctrl #(
    parameter int WIDTH         = 32,
    parameter int MAXBRANCHES   = 16,
    parameter int BRANCHES_ADDR = 4,
    parameter int CNT_W         = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    ras_ctrl_if.slave              bus,
    output logic [BRANCHES_ADDR:0] outstanding,
    output logic                   resolve_err,
    output logic [CNT_W-1:0]       underflow_cnt
);
    localparam logic [BRANCHES_ADDR:0] OUT_MAX = (BRANCHES_ADDR+1)'(MAXBRANCHES);
    localparam logic [BRANCHES_ADDR:0] OUT_ONE = (BRANCHES_ADDR+1)'(1);
    localparam logic [CNT_W-1:0]       CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic {ST_RUN, ST_HOLD} state_t;

    state_t           state;
    state_t           state_nxt;
    logic             holdoff;
    logic             res;
    logic             close_valid;
    logic             close_invalid;
    logic             ready;
    logic             acc;
    logic             pred_valid_q;
    logic             pred_hit_q;
    logic [WIDTH-1:0] target_q;

    assign res           = !rst && bus.resolve_valid && (outstanding != '0);
    assign close_valid   = res && !bus.resolve_mispredict;
    assign close_invalid = res && bus.resolve_mispredict;

    // A full tracker still takes a branch if a correct resolve frees a slot this cycle.
    assign ready = !rst && !holdoff && !close_invalid
                && !(bus.in_is_branch && (outstanding == OUT_MAX) && !close_valid);
    assign acc   = bus.in_valid && ready;

    assign bus.in_ready          = ready;
    assign bus.ras_push          = acc && bus.in_is_call;
    assign bus.ras_pop           = acc && bus.in_is_ret;
    assign bus.ras_branch        = acc && bus.in_is_branch;
    assign bus.ras_close_valid   = close_valid;
    assign bus.ras_close_invalid = close_invalid;
    assign bus.ras_din           = bus.in_pc + (bus.in_is_compressed ? WIDTH'(2) : WIDTH'(4));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // The stack re-reads its link memory for one cycle after a flush.
    always_comb begin
        state_nxt = state;
        holdoff   = 1'b0;
        case (state)
            ST_RUN: begin
                if (close_invalid) state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                holdoff   = 1'b1;
                state_nxt = close_invalid ? ST_HOLD : ST_RUN;
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding <= '0;
        end else if (close_invalid) begin
            outstanding <= '0;
        end else if (bus.ras_branch && !close_valid) begin
            outstanding <= outstanding + OUT_ONE;
        end else if (close_valid && !bus.ras_branch) begin
            outstanding <= outstanding - OUT_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resolve_err <= 1'b0;
        end else if (bus.resolve_valid && (outstanding == '0)) begin
            resolve_err <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            underflow_cnt <= '0;
        end else if (bus.ras_pop && !bus.ras_pop_valid && (underflow_cnt != CNT_MAX)) begin
            underflow_cnt <= underflow_cnt + CNT_W'(1);
        end
    end

    // Stack data arrives the cycle after the pop; it is passed through then and held after.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pred_valid_q <= 1'b0;
            pred_hit_q   <= 1'b0;
            target_q     <= '0;
        end else begin
            pred_valid_q <= bus.ras_pop;
            if (bus.ras_pop) pred_hit_q <= bus.ras_pop_valid;
            if (pred_valid_q) target_q <= bus.ras_dout;
        end
    end

    assign bus.pred_valid  = pred_valid_q;
    assign bus.pred_hit    = pred_hit_q;
    assign bus.pred_target = pred_valid_q ? bus.ras_dout : target_q;
endmodule
